// File: rtl/input_packet_buffer.sv
// Serial-to-packet input stage: assembles put-qualified byte bursts into packets,
// length-checks each burst and queues packets in a first-word-fall-through FIFO.
module input_packet_buffer #(
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned PKT_BYTES = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_LEVEL  = DEPTH - 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          put,
    input  logic [BYTE_W-1:0]             payload,
    input  logic                          read,
    output logic [PKT_BYTES*BYTE_W-1:0]   pkt_out,
    output logic                          pkt_out_avail,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          drop,
    output logic                          short_err,
    output logic                          long_err,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              len_err_cnt
);

    localparam int unsigned PKT_W  = PKT_BYTES * BYTE_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned SLOT_W = $clog2(PKT_BYTES + 1);

    logic [PKT_W-1:0]  asm_q, asm_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              avail_q, full_q, af_q;
    logic              drop_q, drop_d, short_q, short_d, long_q, long_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d, len_cnt_q, len_cnt_d;
    logic [PKT_W-1:0]  mem_q [DEPTH];

    logic              commit_c, push_c, pop_c, is_full_c;
    int unsigned       slot_idx;

    // Assembly, commit decision, FIFO pointer/occupancy and error bookkeeping
    always_comb begin
        asm_d      = asm_q;
        slot_d     = slot_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        len_cnt_d  = len_cnt_q;
        slot_idx   = 0;

        is_full_c = (count_q == OCC_W'(DEPTH));
        commit_c  = !put && (slot_q != '0);
        pop_c     = read && (count_q != '0);
        push_c    = commit_c && (!is_full_c || read);
        drop_d    = commit_c && is_full_c && !read;
        short_d   = commit_c && (slot_q < SLOT_W'(PKT_BYTES));
        long_d    = commit_c && ovf_q;

        if (put) begin
            if (slot_q < SLOT_W'(PKT_BYTES)) begin
                slot_idx = PKT_BYTES - 1 - 32'(slot_q);
                asm_d[slot_idx*BYTE_W +: BYTE_W] = payload;
                slot_d = slot_q + SLOT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (commit_c) begin
            asm_d  = '0;
            slot_d = '0;
            ovf_d  = 1'b0;
        end

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + OCC_W'(push_c) - OCC_W'(pop_c);

        // Event counters stick at all-ones instead of wrapping
        if (drop_d && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        if ((short_d || long_d) && (len_cnt_q != '1))
            len_cnt_d = len_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            asm_q      <= '0;
            slot_q     <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            avail_q    <= 1'b0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            drop_q     <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            drop_cnt_q <= '0;
            len_cnt_q  <= '0;
        end else begin
            asm_q      <= asm_d;
            slot_q     <= slot_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            avail_q    <= (count_d != '0);
            full_q     <= (count_d == OCC_W'(DEPTH));
            af_q       <= (count_d >= OCC_W'(AF_LEVEL));
            drop_q     <= drop_d;
            short_q    <= short_d;
            long_q     <= long_d;
            drop_cnt_q <= drop_cnt_d;
            len_cnt_q  <= len_cnt_d;
        end
    end

    // Packet storage; when full with a read, the write reuses the slot being popped
    always_ff @(posedge clock) begin
        if (reset_n && push_c)
            mem_q[wr_ptr_q] <= asm_q;
    end

    always_comb begin
        pkt_out = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    assign pkt_out_avail = avail_q;
    assign full          = full_q;
    assign almost_full   = af_q;
    assign count         = count_q;
    assign drop          = drop_q;
    assign short_err     = short_q;
    assign long_err      = long_q;
    assign drop_cnt      = drop_cnt_q;
    assign len_err_cnt   = len_cnt_q;

endmodule
